pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter FWD_EN, default 1, meaning 1 = forwarding mode and 0 = stall-only mode.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 id_valid  in  1  decode stage holds a valid instruction.
REQ-007 id_rs1, id_rs2  in  RA_W each  decode source registers.
REQ-008 id_use_rs1, id_use_rs2  in  1 each  the source register is actually read.
REQ-009 id_rd  in  RA_W  decode destination register.
REQ-010 id_reg_write, id_is_load  in  1 each  decode writes rd / decode is a load.
REQ-011 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-012 ex_busy  in  1  multi-cycle EX operation not finished.
REQ-013 pc_stall, if_id_stall  out  1 each  hold PC / hold IF/ID.
REQ-014 if_id_flush, id_ex_bubble  out  1 each  clear IF/ID / load a bubble into ID/EX.
REQ-015 fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-016 wb_reg_write, wb_rd  out  1, RA_W  regfile write enable and address for WB.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-018 The block SHALL track EX, MEM and WB stage records, each holding {valid, rd, reg_write, is_load}; the EX record SHALL also hold rs1/rs2 and their use bits.
REQ-019 A source register SHALL "match" a stage record only when the use bit is set, the record is valid with reg_write=1, rd equals the source register, and rd is nonzero.
REQ-020 A load-use hazard (FWD_EN=1) SHALL exist when id_valid=1 and an ID source matches the EX record with is_load=1.
REQ-021 A data hazard (FWD_EN=0) SHALL exist when id_valid=1 and an ID source matches the EX, MEM or WB record.
REQ-022 A stall SHALL be defined as a hazard with ex_busy=0 and ex_branch_taken=0; it SHALL assert pc_stall, if_id_stall and id_ex_bubble in the same cycle (combinational outputs).
REQ-023 A flush SHALL be defined as ex_branch_taken=1 with ex_busy=0; it SHALL assert if_id_flush and id_ex_bubble; pc_stall SHALL remain 0.
REQ-024 Flush SHALL take priority over stall in the same cycle.
REQ-025 ex_busy=1 SHALL assert pc_stall and if_id_stall and SHALL freeze all EX/MEM/WB records; ex_branch_taken SHALL be ignored while ex_busy=1.
REQ-026 When ex_busy=1, wb_reg_write SHALL be 0 and the WB record SHALL be consumed exactly once, on the first cycle ex_busy falls.
REQ-027 When not busy, each edge SHALL advance WB<=MEM and MEM<=EX; EX SHALL load an invalid record on stall or flush, and the ID fields gated by id_valid otherwise.
REQ-028 fwd_a/fwd_b SHALL be combinational from the EX record: a MEM match SHALL give 01 (priority), else a WB match SHALL give 10, else 00; with FWD_EN=0 both SHALL be tied to 00.
REQ-029 wb_reg_write SHALL equal WB valid & reg_write & (rd != 0), and wb_rd SHALL equal the WB rd.
REQ-030 stall_cnt SHALL increment once per cycle with stall or ex_busy; flush_cnt SHALL increment once per flush cycle; both SHALL saturate at all-ones with no wrap.
REQ-031 Stall latency SHALL be 1 cycle per load-use hazard in FWD_EN=1 mode, and until the producer leaves WB in FWD_EN=0 mode.

Reset
REQ-032 With reset=0 at an edge, all stage records SHALL become invalid and both counters SHALL become zero; reset SHALL take priority over busy, stall and flush.
REQ-033 During and directly after reset, all outputs SHALL be 0 (fwd = 00) until non-reset inputs create a hazard.
REQ-034 A reset asserted mid-stall or mid-busy SHALL discard the in-flight records with no WB write.

Structure
REQ-035 A shared package pipe_pkg SHALL hold the fwd_sel_e enum (FWD_RF, FWD_MEM, FWD_WB) and the stage_rec_t struct.
REQ-036 Combinational match/hazard logic SHALL reside in one sub-module pipe_hazard_detect; the stage records and counters SHALL reside in the top.

Verification
REQ-037 FWD_EN=1: lw x5 in EX, ID add x6,x5,x1 -> one stall cycle (pc_stall=1), then fwd_a=10 when the add is in EX; stall_cnt=1.
REQ-038 FWD_EN=1: add x3 in EX, ID sub x4,x3,x3 -> no stall; next cycle fwd_a=01 and fwd_b=01.
REQ-039 FWD_EN=0: same add/sub sequence -> 3 stall cycles; fwd_a=fwd_b=00 throughout.
REQ-040 ex_branch_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
REQ-041 ex_busy held for 4 cycles with a valid WB write to x7 -> wb_reg_write=0 for 4 cycles, then exactly one write to x7; stall_cnt=4.
REQ-042 CNT_W=4 with 20 stall cycles -> stall_cnt=15; rd=x0 producer -> never matches and never writes.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the in-order pipeline hazard controller: forwarding
// selector encoding, per-stage bookkeeping records and the register-match rule.
package pipe_pkg;

  // Storage width for register addresses inside stage records. Narrower
  // address widths are zero-extended into it, so RA_W must not exceed it.
  localparam int RA_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // What a downstream stage needs to know about the instruction it holds.
  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } stage_rec_t;

  // Source operands; kept for the instruction in EX to drive forwarding.
  typedef struct packed {
    logic [RA_W_MAX-1:0] rs1;
    logic [RA_W_MAX-1:0] rs2;
    logic                use_rs1;
    logic                use_rs2;
  } src_rec_t;

  // A source depends on a stage only if the source is really read and the
  // stage will write that same, nonzero register.
  function automatic logic src_match(input logic                use_src,
                                     input logic [RA_W_MAX-1:0] src,
                                     input stage_rec_t          rec);
    return use_src && rec.valid && rec.reg_write &&
           (rec.rd == src) && (rec.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational dependency checker: decides whether the instruction in ID
// must wait, and where EX should take each operand from.
module pipe_hazard_detect
  import pipe_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic       i_id_valid,
  input  src_rec_t   i_id_src,
  input  stage_rec_t i_ex_rec,
  input  src_rec_t   i_ex_src,
  input  stage_rec_t i_mem_rec,
  input  stage_rec_t i_wb_rec,
  output logic       o_hazard,
  output fwd_sel_e   o_fwd_a,
  output fwd_sel_e   o_fwd_b
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = src_match(i_id_src.use_rs1, i_id_src.rs1, i_ex_rec)
                   | src_match(i_id_src.use_rs2, i_id_src.rs2, i_ex_rec);
  assign w_mem_hit = src_match(i_id_src.use_rs1, i_id_src.rs1, i_mem_rec)
                   | src_match(i_id_src.use_rs2, i_id_src.rs2, i_mem_rec);
  assign w_wb_hit  = src_match(i_id_src.use_rs1, i_id_src.rs1, i_wb_rec)
                   | src_match(i_id_src.use_rs2, i_id_src.rs2, i_wb_rec);

  // With forwarding only a load in EX is too late; without it any pending write is.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    o_hazard = 1'b0;
    if (i_id_valid) begin
      if (FWD_EN != 0) o_hazard = w_ex_hit & i_ex_rec.is_load;
      else             o_hazard = w_ex_hit | w_mem_hit | w_wb_hit;
    end
  end

  // Operand source for EX: the younger producer (MEM) wins over WB.
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (FWD_EN != 0) begin
      if (src_match(i_ex_src.use_rs1, i_ex_src.rs1, i_mem_rec))     o_fwd_a = FWD_MEM;
      else if (src_match(i_ex_src.use_rs1, i_ex_src.rs1, i_wb_rec)) o_fwd_a = FWD_WB;
      if (src_match(i_ex_src.use_rs2, i_ex_src.rs2, i_mem_rec))     o_fwd_b = FWD_MEM;
      else if (src_match(i_ex_src.use_rs2, i_ex_src.rs2, i_wb_rec)) o_fwd_b = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control for a 5-stage in-order core: tracks EX/MEM/WB occupancy,
// issues stall/flush/bubble controls, forwarding selects, the WB write
// strobe and saturating stall/flush event counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             wb_reg_write,
  output logic [RA_W-1:0]  wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_rec_t       r_ex;
  src_rec_t         r_ex_src;
  stage_rec_t       r_mem;
  stage_rec_t       r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  stage_rec_t w_id_rec;
  src_rec_t   w_id_src;
  logic       w_hazard;
  fwd_sel_e   w_fwd_a;
  fwd_sel_e   w_fwd_b;
  logic       w_stall;
  logic       w_flush;
  logic       w_run;

  // Decode fields, zeroed when ID is empty so a bubble carries no use bits.
  always_comb begin
    w_id_rec = '0;
    w_id_src = '0;
    if (id_valid) begin
      w_id_rec.valid     = 1'b1;
      w_id_rec.rd        = RA_W_MAX'(id_rd);
      w_id_rec.reg_write = id_reg_write;
      w_id_rec.is_load   = id_is_load;
      w_id_src.rs1       = RA_W_MAX'(id_rs1);
      w_id_src.rs2       = RA_W_MAX'(id_rs2);
      w_id_src.use_rs1   = id_use_rs1;
      w_id_src.use_rs2   = id_use_rs2;
    end
  end

  pipe_hazard_detect #(
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .i_id_valid (id_valid),
    .i_id_src   (w_id_src),
    .i_ex_rec   (r_ex),
    .i_ex_src   (r_ex_src),
    .i_mem_rec  (r_mem),
    .i_wb_rec   (r_wb),
    .o_hazard   (w_hazard),
    .o_fwd_a    (w_fwd_a),
    .o_fwd_b    (w_fwd_b)
  );

  // Busy freezes everything; a taken branch outranks a stall.
  assign w_stall = w_hazard & ~ex_busy & ~ex_branch_taken;
  assign w_flush = ex_branch_taken & ~ex_busy;

  // Controls are silenced while reset is held so nothing moves or writes.
  assign w_run        = reset;
  assign pc_stall     = w_run & (w_stall | ex_busy);
  assign if_id_stall  = w_run & (w_stall | ex_busy);
  assign if_id_flush  = w_run & w_flush;
  assign id_ex_bubble = w_run & (w_stall | w_flush);
  assign fwd_a        = w_run ? w_fwd_a : FWD_RF;
  assign fwd_b        = w_run ? w_fwd_b : FWD_RF;
  assign wb_reg_write = w_run & ~ex_busy & r_wb.valid & r_wb.reg_write & (r_wb.rd != '0);
  assign wb_rd        = w_run ? r_wb.rd[RA_W-1:0] : '0;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  // Stage records: advance when not busy; EX takes a bubble on stall/flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every record
    // shifts from its pre-edge neighbour rather than a just-updated one.
    if (!reset) begin
      r_ex     <= '0;
      r_ex_src <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
    end else if (!ex_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_stall || w_flush) begin
        r_ex     <= '0;
        r_ex_src <= '0;
      end else begin
        r_ex     <= w_id_rec;
        r_ex_src <= w_id_src;
      end
    end
  end

  // Saturating event counters: busy cycles count as stall cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_stall || ex_busy) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: three instances (forwarding,
// stall-only, forwarding with 4-bit counters) share one stimulus stream and
// are compared against an instruction-level model of the pipeline.
module tb_pipeline_ctrl;

  localparam int RA_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            ex_branch_taken, ex_busy;

  logic            o_pc_stall[3], o_if_id_stall[3], o_flush[3], o_bubble[3], o_wbw[3];
  logic [1:0]      o_fwd_a[3], o_fwd_b[3];
  logic [RA_W-1:0] o_wb_rd[3];
  logic [15:0]     o_scnt[2], o_fcnt[2];
  logic [3:0]      c4_scnt, c4_fcnt;

  pipeline_ctrl #(.RA_W(RA_W), .FWD_EN(1), .CNT_W(16)) dut_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_stall(o_pc_stall[0]), .if_id_stall(o_if_id_stall[0]), .if_id_flush(o_flush[0]),
    .id_ex_bubble(o_bubble[0]), .fwd_a(o_fwd_a[0]), .fwd_b(o_fwd_b[0]),
    .wb_reg_write(o_wbw[0]), .wb_rd(o_wb_rd[0]), .stall_cnt(o_scnt[0]), .flush_cnt(o_fcnt[0]));

  pipeline_ctrl #(.RA_W(RA_W), .FWD_EN(0), .CNT_W(16)) dut_stl (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_stall(o_pc_stall[1]), .if_id_stall(o_if_id_stall[1]), .if_id_flush(o_flush[1]),
    .id_ex_bubble(o_bubble[1]), .fwd_a(o_fwd_a[1]), .fwd_b(o_fwd_b[1]),
    .wb_reg_write(o_wbw[1]), .wb_rd(o_wb_rd[1]), .stall_cnt(o_scnt[1]), .flush_cnt(o_fcnt[1]));

  pipeline_ctrl #(.RA_W(RA_W), .FWD_EN(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .ex_busy(ex_busy),
    .pc_stall(o_pc_stall[2]), .if_id_stall(o_if_id_stall[2]), .if_id_flush(o_flush[2]),
    .id_ex_bubble(o_bubble[2]), .fwd_a(o_fwd_a[2]), .fwd_b(o_fwd_b[2]),
    .wb_reg_write(o_wbw[2]), .wb_rd(o_wb_rd[2]), .stall_cnt(c4_scnt), .flush_cnt(c4_fcnt));

  // ---------------- reference model ----------------
  // An in-flight instruction; slot 0 = EX, 1 = MEM, 2 = WB. Mode 0 is the
  // forwarding pipeline, mode 1 the stall-only pipeline.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
    bit u1;
    bit u2;
    int rs1;
    int rs2;
  } ins_t;

  ins_t m_pipe[2][3];
  int   m_stalls[2];
  int   m_flushes[2];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit depends(bit u, int s, ins_t p);
    return u && p.v && p.rw && (p.rd == s) && (s != 0);
  endfunction

  function automatic ins_t id_ins();
    ins_t i;
    i.v = id_valid; i.rd = int'(id_rd); i.rw = id_reg_write; i.ld = id_is_load;
    i.u1 = id_use_rs1; i.u2 = id_use_rs2; i.rs1 = int'(id_rs1); i.rs2 = int'(id_rs2);
    return i;
  endfunction

  // Must the ID instruction wait? Forwarding covers everything except a
  // load whose data is not ready until after MEM.
  function automatic bit must_wait(int m);
    ins_t i = id_ins();
    if (!i.v) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m == 0 && (k != 0 || !m_pipe[m][0].ld)) continue;
      if (depends(i.u1, i.rs1, m_pipe[m][k]) || depends(i.u2, i.rs2, m_pipe[m][k]))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int fwd_src(int m, bit u, int s);
    if (m == 1) return 0;
    if (depends(u, s, m_pipe[m][1])) return 1;
    if (depends(u, s, m_pipe[m][2])) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    ins_t empty = '{default: 0};
    for (int m = 0; m < 2; m++) begin
      bit st = must_wait(m) && !ex_busy && !ex_branch_taken;
      bit fl = ex_branch_taken && !ex_busy;
      if (!reset) begin
        for (int k = 0; k < 3; k++) m_pipe[m][k] = empty;
        m_stalls[m] = 0;
        m_flushes[m] = 0;
      end else if (ex_busy) begin
        m_stalls[m]++;
      end else begin
        if (st) m_stalls[m]++;
        if (fl) m_flushes[m]++;
        m_pipe[m][2] = m_pipe[m][1];
        m_pipe[m][1] = m_pipe[m][0];
        m_pipe[m][0] = (st || fl || !id_valid) ? empty : id_ins();
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      int   m   = (d == 1) ? 1 : 0;
      int   sat = (d == 2) ? 15 : 65535;
      bit   run = reset;
      bit   st  = run && must_wait(m) && !ex_busy && !ex_branch_taken;
      bit   fl  = run && ex_branch_taken && !ex_busy;
      ins_t wb  = m_pipe[m][2];
      ins_t ex  = m_pipe[m][0];
      logic [31:0] sc = (d == 2) ? 32'(c4_scnt) : 32'(o_scnt[d]);
      logic [31:0] fc = (d == 2) ? 32'(c4_fcnt) : 32'(o_fcnt[d]);
      check($sformatf("d%0d.pc_stall", d), 32'(o_pc_stall[d]), 32'(st || (run && ex_busy)));
      check($sformatf("d%0d.if_id_stall", d), 32'(o_if_id_stall[d]), 32'(st || (run && ex_busy)));
      check($sformatf("d%0d.if_id_flush", d), 32'(o_flush[d]), 32'(fl));
      check($sformatf("d%0d.id_ex_bubble", d), 32'(o_bubble[d]), 32'(st || fl));
      check($sformatf("d%0d.fwd_a", d), 32'(o_fwd_a[d]), run ? fwd_src(m, ex.u1, ex.rs1) : 0);
      check($sformatf("d%0d.fwd_b", d), 32'(o_fwd_b[d]), run ? fwd_src(m, ex.u2, ex.rs2) : 0);
      check($sformatf("d%0d.wb_reg_write", d), 32'(o_wbw[d]),
            32'(run && !ex_busy && wb.v && wb.rw && wb.rd != 0));
      check($sformatf("d%0d.wb_rd", d), 32'(o_wb_rd[d]), run ? wb.rd : 0);
      check($sformatf("d%0d.stall_cnt", d), sc, (m_stalls[m] > sat) ? sat : m_stalls[m]);
      check($sformatf("d%0d.flush_cnt", d), fc, (m_flushes[m] > sat) ? sat : m_flushes[m]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit ld);
    id_valid = v; id_rs1 = RA_W'(rs1); id_use_rs1 = u1; id_rs2 = RA_W'(rs2);
    id_use_rs2 = u2; id_rd = RA_W'(rd); id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ex_busy = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    settle();
    reset = 1'b1;
  endtask

  initial begin
    int n_st;
    int n_nz;
    reset = 1'b0;
    ex_busy = 1'b0;
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    settle();
    check("reset.pc_stall", 32'(o_pc_stall[0]), 0);
    check("reset.stall_cnt", 32'(o_scnt[0]), 0);

    // Load-use with forwarding: one bubble, then the load value comes from WB.
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    settle(); tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    settle();
    check("lu.pc_stall", 32'(o_pc_stall[0]), 1);
    check("lu.bubble", 32'(o_bubble[0]), 1);
    tick(); settle();
    check("lu.released", 32'(o_pc_stall[0]), 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("lu.fwd_a", 32'(o_fwd_a[0]), 2);
    check("lu.fwd_b", 32'(o_fwd_b[0]), 0);
    check("lu.stall_cnt", 32'(o_scnt[0]), 1);

    // ALU dependency: forwarded from MEM, or three stalls without forwarding.
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    settle(); tick();
    set_id(1, 3, 1, 3, 1, 4, 1, 0);
    n_st = 0;
    n_nz = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (i == 0) check("alu.no_stall", 32'(o_pc_stall[0]), 0);
      if (i == 1) begin
        check("alu.fwd_a", 32'(o_fwd_a[0]), 1);
        check("alu.fwd_b", 32'(o_fwd_b[0]), 1);
      end
      n_st += int'(o_pc_stall[1]);
      if (o_fwd_a[1] != 2'b00 || o_fwd_b[1] != 2'b00) n_nz++;
      tick();
    end
    settle();
    check("stl.stall_cycles", n_st, 3);
    check("stl.fwd_nonzero", n_nz, 0);
    check("stl.stall_cnt", 32'(o_scnt[1]), 3);

    // Taken branch beats a simultaneous load-use hazard.
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    settle(); tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    ex_branch_taken = 1'b1;
    settle();
    check("br.flush", 32'(o_flush[0]), 1);
    check("br.bubble", 32'(o_bubble[0]), 1);
    check("br.pc_stall", 32'(o_pc_stall[0]), 0);
    tick();
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("br.flush_cnt", 32'(o_fcnt[0]), 1);
    check("br.stall_cnt", 32'(o_scnt[0]), 0);

    // Busy holds a pending x7 write back until busy drops, then writes once.
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    settle(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    settle(); tick();
    settle(); tick();
    ex_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("busy.wb_held", 32'(o_wbw[0]), 0);
      tick();
    end
    ex_busy = 1'b0;
    settle();
    check("busy.wb_write", 32'(o_wbw[0]), 1);
    check("busy.wb_rd", 32'(o_wb_rd[0]), 7);
    tick(); settle();
    check("busy.wb_once", 32'(o_wbw[0]), 0);
    check("busy.stall_cnt", 32'(o_scnt[0]), 4);

    // Saturation of the narrow counter, and x0 producers.
    do_reset();
    ex_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle(); tick();
    end
    ex_busy = 1'b0;
    settle();
    check("sat.c4_stall_cnt", 32'(c4_scnt), 15);
    check("sat.c16_stall_cnt", 32'(o_scnt[0]), 20);
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    settle(); tick();
    set_id(1, 0, 1, 0, 1, 4, 1, 0);
    settle();
    check("x0.no_stall_fwd", 32'(o_pc_stall[0]), 0);
    check("x0.no_stall_stl", 32'(o_pc_stall[1]), 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); settle();
    check("x0.no_write", 32'(o_wbw[0]), 0);

    // Reset during busy drops the pending write.
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    settle(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    ex_busy = 1'b1;
    settle(); tick();
    reset = 1'b0;
    settle();
    check("rstbusy.pc_stall", 32'(o_pc_stall[0]), 0);
    check("rstbusy.wbw_in", 32'(o_wbw[0]), 0);
    tick();
    reset = 1'b1;
    ex_busy = 1'b0;
    settle();
    check("rstbusy.wbw_after", 32'(o_wbw[0]), 0);
    check("rstbusy.stall_cnt", 32'(o_scnt[0]), 0);

    // Randomized traffic on a small register set to provoke dependencies.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 59) != 0);
      ex_busy         = ($urandom_range(0, 6) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
